regfile_mp: RTL and testbench

- Parametrised multi-port register file for the single-cycle/pipelined MIPS core.
- Successor to the 32x32 two-read/one-write file. Adds the following:
  - configurable width and depth
  - a second write port
  - hardwired zero register
  - same-cycle write-to-read bypass
  - per-register pending-write scoreboard for hazard detection in the pipelined datapath.

---
 rtl/regfile_mp.sv | 157 +++++++++++++++
 tb/tb_regfile_mp.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with two combinational read ports,
// two write ports (port 1 wins on an address collision), an optional
// hardwired zero register, optional same-cycle write-to-read bypass, and a
// per-register pending-write scoreboard with a registered busy count.
// Optional feature macro: RF_PARITY_EN adds one even-parity bit per entry
// and the parity_err_a / parity_err_b outputs.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
`ifdef RF_PARITY_EN
  output logic              parity_err_a,
  output logic              parity_err_b,
`endif
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NUM_REGS = 2**ADDR_W;

  // Storage and scoreboard state
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy_q;
  logic [NUM_REGS-1:0]             busy_d;
  logic [ADDR_W:0]                 cnt_q;
  logic [ADDR_W:0]                 cnt_d;

  // Qualified requests
  logic we0;
  logic we1;
  logic we0_store;
  logic rsv_ok;

  // Read-side intermediate terms
  logic zero_a;
  logic zero_b;
  logic byp1_a;
  logic byp0_a;
  logic byp1_b;
  logic byp0_b;

  // Qualify writes/reserves: ignored in reset, dropped for the hardwired zero register
  always_comb begin
    we0       = wr_en0 && !rst && !((ZERO_REG != 0) && (wr_addr0 == '0));
    we1       = wr_en1 && !rst && !((ZERO_REG != 0) && (wr_addr1 == '0));
    rsv_ok    = rsv_en && !rst && !((ZERO_REG != 0) && (rsv_addr == '0));
    we0_store = we0 && !(we1 && (wr_addr1 == wr_addr0));
  end

  // Register array update; port 1 is applied last so it wins on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      if (we0_store) regs[wr_addr0] <= wr_data0;
      if (we1)       regs[wr_addr1] <= wr_data1;
    end
  end

  // Scoreboard next state: writes clear, then a reserve sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (we0)    busy_d[wr_addr0] = 1'b0;
    if (we1)    busy_d[wr_addr1] = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Population count of the next scoreboard value, registered with the bits
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Scoreboard bits and busy count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read-port hit detection against the qualified write ports
  always_comb begin
    zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
    zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);
    byp1_a = (BYPASS != 0) && we1 && (wr_addr1 == rd_addr_a);
    byp0_a = (BYPASS != 0) && we0 && (wr_addr0 == rd_addr_a);
    byp1_b = (BYPASS != 0) && we1 && (wr_addr1 == rd_addr_b);
    byp0_b = (BYPASS != 0) && we0 && (wr_addr0 == rd_addr_b);
  end

  // Read data mux: zero register, then bypass (port 1 first), then storage
  always_comb begin
    if (zero_a)      rd_data_a = '0;
    else if (byp1_a) rd_data_a = wr_data1;
    else if (byp0_a) rd_data_a = wr_data0;
    else             rd_data_a = regs[rd_addr_a];

    if (zero_b)      rd_data_b = '0;
    else if (byp1_b) rd_data_b = wr_data1;
    else if (byp0_b) rd_data_b = wr_data0;
    else             rd_data_b = regs[rd_addr_b];
  end

  // Scoreboard outputs reflect stored state only
  always_comb begin
    busy_a   = busy_q[rd_addr_a];
    busy_b   = busy_q[rd_addr_b];
    busy_cnt = cnt_q;
  end

`ifdef RF_PARITY_EN
  logic [NUM_REGS-1:0] par_q;

  // Even-parity bit captured alongside the write data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= '0;
    end else begin
      if (we0_store) par_q[wr_addr0] <= ^wr_data0;
      if (we1)       par_q[wr_addr1] <= ^wr_data1;
    end
  end

  // Parity check of the stored word; bypassed and zero-register reads report clean
  always_comb begin
    parity_err_a = !zero_a && !byp1_a && !byp0_a &&
                   ((^regs[rd_addr_a]) != par_q[rd_addr_a]);
    parity_err_b = !zero_b && !byp1_b && !byp0_b &&
                   ((^regs[rd_addr_b]) != par_q[rd_addr_b]);
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a default instance (BYPASS=1,
// ZERO_REG=1) and a second instance (BYPASS=0, ZERO_REG=0) share all inputs
// and are compared against an array-based reference model.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        wr_en0, wr_en1, rsv_en;
  logic [4:0]  wr_addr0, wr_addr1, rsv_addr;
  logic [31:0] wr_data0, wr_data1;

  logic [31:0] rda0, rdb0, rda1, rdb1;
  logic        ba0, bb0, ba1, bb1;
  logic [5:0]  cnt0, cnt1;
`ifdef RF_PARITY_EN
  logic        pea0, peb0, pea1, peb1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: index 0 = default instance, 1 = no-bypass/no-zero instance
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  bit          m_byp  [2] = '{1'b1, 1'b0};
  bit          m_zr   [2] = '{1'b1, 1'b0};
`ifdef RF_PARITY_EN
  bit          m_pbad [32];
`endif

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda0),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
    .busy_a(ba0), .busy_b(bb0),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
`ifdef RF_PARITY_EN
    .parity_err_a(pea0), .parity_err_b(peb0),
`endif
    .busy_cnt(cnt0)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda1),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
    .busy_a(ba1), .busy_b(bb1),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
`ifdef RF_PARITY_EN
    .parity_err_a(pea1), .parity_err_b(peb1),
`endif
    .busy_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
    if (rst) return 32'h0;
    if (m_zr[c] && a == 5'd0) return 32'h0;
    if (m_byp[c] && wr_en1 && wr_addr1 == a && !(m_zr[c] && wr_addr1 == 5'd0)) return wr_data1;
    if (m_byp[c] && wr_en0 && wr_addr0 == a && !(m_zr[c] && wr_addr0 == 5'd0)) return wr_data0;
    return m_mem[c][a];
  endfunction

  function automatic logic [5:0] exp_cnt(input int c);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(m_busy[c][i]);
    return 6'(s);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_mem[c][i]  = 32'h0;
        m_busy[c][i] = 1'b0;
      end
`ifdef RF_PARITY_EN
    for (int i = 0; i < 32; i++) m_pbad[i] = 1'b0;
`endif
  endtask

  // Architectural effect of one rising edge on each model
  task automatic model_edge();
    if (rst) return;
    for (int c = 0; c < 2; c++) begin
      if (wr_en0 && !(m_zr[c] && wr_addr0 == 5'd0)) m_mem[c][wr_addr0] = wr_data0;
      if (wr_en1 && !(m_zr[c] && wr_addr1 == 5'd0)) m_mem[c][wr_addr1] = wr_data1;
      if (wr_en0) m_busy[c][wr_addr0] = 1'b0;
      if (wr_en1) m_busy[c][wr_addr1] = 1'b0;
      if (rsv_en) m_busy[c][rsv_addr] = 1'b1;
      if (m_zr[c]) m_busy[c][0] = 1'b0;
    end
`ifdef RF_PARITY_EN
    if (wr_en0) m_pbad[wr_addr0] = 1'b0;
    if (wr_en1) m_pbad[wr_addr1] = 1'b0;
`endif
  endtask

  task automatic check_model();
    logic [31:0] ga, gb;
    logic        xa, xb;
    logic [5:0]  gc;
    for (int c = 0; c < 2; c++) begin
      ga = (c == 0) ? rda0 : rda1;
      gb = (c == 0) ? rdb0 : rdb1;
      xa = (c == 0) ? ba0  : ba1;
      xb = (c == 0) ? bb0  : bb1;
      gc = (c == 0) ? cnt0 : cnt1;
      check($sformatf("i%0d rd_a[%0d]", c, rd_addr_a), 64'(ga), 64'(exp_rd(c, rd_addr_a)));
      check($sformatf("i%0d rd_b[%0d]", c, rd_addr_b), 64'(gb), 64'(exp_rd(c, rd_addr_b)));
      check($sformatf("i%0d busy_a", c), 64'(xa), 64'(m_busy[c][rd_addr_a]));
      check($sformatf("i%0d busy_b", c), 64'(xb), 64'(m_busy[c][rd_addr_b]));
      check($sformatf("i%0d busy_cnt", c), 64'(gc), 64'(exp_cnt(c)));
    end
`ifdef RF_PARITY_EN
    begin
      logic byp_a;
      byp_a = (wr_en1 && wr_addr1 == rd_addr_a) || (wr_en0 && wr_addr0 == rd_addr_a);
      check("i0 parity_a", 64'(pea0),
            64'(!rst && rd_addr_a != 5'd0 && !byp_a && m_pbad[rd_addr_a]));
    end
`endif
  endtask

  task automatic drive(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic rv, input logic [4:0] ra,
                       input logic [4:0] qa, input logic [4:0] qb);
    wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
    wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
    rsv_en = rv; rsv_addr = ra;
    rd_addr_a = qa; rd_addr_b = qb;
  endtask

  task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, qa, qb);
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 9));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1;
    idle(5'd0, 5'd0);
    model_reset();
    @(negedge clk);

    // Reset state: every address reads zero, nothing busy
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      #1;
      check("rst rd_a", 64'(rda0), 64'h0);
      check("rst rd_b", 64'(rdb1), 64'h0);
    end
    check("rst cnt", 64'(cnt0), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write r3 via port 0: bypass instance sees it now, the other after the edge
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    settle();
    check("r3 byp same", 64'(rda0), 64'hDEADBEEF);
    check("r3 nobyp same", 64'(rda1), 64'h0);
    edge_step();
    idle(5'd3, 5'd0);
    settle();
    check("r3 next", 64'(rda0), 64'hDEADBEEF);
    check("r3 nobyp next", 64'(rda1), 64'hDEADBEEF);

    // Dual write to r7: port 1 wins, including on the bypass path
    drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    settle();
    check("r7 byp", 64'(rda0), 64'h22);
    edge_step();
    idle(5'd7, 5'd7);
    settle();
    check("r7 stored", 64'(rda0), 64'h22);
    check("r7 stored nb", 64'(rdb1), 64'h22);

    // Zero register: write and reserve to r0 are dropped
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    settle();
    check("r0 byp", 64'(rda0), 64'h0);
    edge_step();
    idle(5'd0, 5'd0);
    settle();
    check("r0 rd", 64'(rda0), 64'h0);
    check("r0 busy", 64'(ba0), 64'h0);
    check("r0 cnt", 64'(cnt0), 64'h0);
    check("r0 nz rd", 64'(rda1), 64'hFFFFFFFF);

    // Scoreboard sequence on the default instance
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9);
    settle();
    check("rsv4 pre busy", 64'(ba0), 64'h0);
    edge_step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd4, 5'd9);
    settle();
    check("rsv4 busy", 64'(ba0), 64'h1);
    check("rsv4 cnt", 64'(cnt0), 64'h1);
    edge_step();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9);
    settle();
    check("rsv9 cnt", 64'(cnt0), 64'h2);
    edge_step();
    drive(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    settle();
    check("wr+rsv4 busy", 64'(ba0), 64'h1);
    check("wr+rsv4 cnt", 64'(cnt0), 64'h2);
    edge_step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd4, 5'd9);
    settle();
    check("wr4 cnt", 64'(cnt0), 64'h1);
    edge_step();
    idle(5'd4, 5'd9);
    settle();
    check("wr9 cnt", 64'(cnt0), 64'h0);
    check("wr9 busy", 64'(bb0), 64'h0);

`ifdef RF_PARITY_EN
    // Parity: corrupt one stored bit of r12 and expect detection
    drive(1'b1, 5'd12, 32'h0000000F, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    settle();
    edge_step();
    idle(5'd12, 5'd0);
    force dut.regs[12] = 32'h0000000E;
    #1;
    release dut.regs[12];
    m_mem[0][12] = 32'h0000000E;
    m_pbad[12] = 1'b1;
    settle();
    check("par flip", 64'(pea0), 64'h1);
    edge_step();
    drive(1'b1, 5'd12, 32'h0000000F, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    settle();
    edge_step();
    idle(5'd12, 5'd0);
    settle();
    check("par rewrite", 64'(pea0), 64'h0);
`endif

    // Asynchronous reset mid-cycle clears data without a clock edge
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    settle();
    edge_step();
    idle(5'd5, 5'd5);
    settle();
    check("r5 before rst", 64'(rda0), 64'h1234);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("r5 async rst", 64'(rda0), 64'h0);
    check("r5 async rst nb", 64'(rdb1), 64'h0);
    check_model();
    edge_step();
    rst = 1'b0;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 2) == 0), rnd_addr(),
            rnd_addr(), rnd_addr());
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      settle();
      edge_step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
